ioctl_sdram_writer: RTL and testbench



---
 rtl/ioctl_sdram_writer.sv | 153 +++++++++++++++
 tb/tb_ioctl_sdram_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_writer.sv
// ioctl_sdram_writer: packs the hps_io 8-bit download stream into 32-bit
// little-endian words and issues them as SDRAM write requests over req/ack.
`default_nettype none

module ioctl_sdram_writer #(
  parameter logic [22:0] BASE_ADDR = 23'h0,
  parameter logic [7:0]  PAD_BYTE  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic [22:0] words_written,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        dl_q;
  logic [31:0] asm_q;
  logic [3:0]  mask_q;
  logic [22:0] base_q;
  logic        full_q;
  logic        pend_q;
  logic [22:0] paddr_q;
  logic [31:0] pdata_q;
  logic [22:0] words_q;
  logic        ovf_q;
  logic        done_q;

  logic        rise;
  logic        accept;
  logic        ack_hit;
  logic        pend_free;
  logic        jump;
  logic        flush_tail;
  logic        move;
  logic [22:0] wr_base;
  logic [22:0] word_addr;
  logic [31:0] padded;

  assign wr_base    = ioctl_addr[24:2];
  assign rise       = ioctl_download & ~dl_q;
  assign accept     = ioctl_wr && (state_q == S_LOAD);
  assign ack_hit    = pend_q && sdram_ack;
  assign pend_free  = !pend_q || sdram_ack;
  assign jump       = accept && !full_q && (mask_q != 4'h0) && (wr_base != base_q);
  assign flush_tail = (state_q == S_FLUSH) && !full_q && (mask_q != 4'h0) && pend_free;
  // A completed word is handed over on the edge after its lane-3 byte lands.
  assign move       = full_q || jump || flush_tail;
  assign word_addr  = BASE_ADDR + {base_q[21:0], 1'b0};

  always_comb begin
    padded = '0;
    for (int k = 0; k < 4; k++) begin
      padded[8*k +: 8] = mask_q[k] ? asm_q[8*k +: 8] : PAD_BYTE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      asm_q   <= '0;
      mask_q  <= '0;
      base_q  <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      done_q <= 1'b0;

      if (ack_hit) begin
        pend_q <= 1'b0;
        if (words_q != '1) words_q <= words_q + 23'd1;
      end

      // Pending slot is refilled on the ack edge itself, so req stays high.
      if (move) begin
        if (pend_free) begin
          pend_q  <= 1'b1;
          paddr_q <= word_addr;
          pdata_q <= padded;
        end else begin
          ovf_q <= 1'b1;
        end
        mask_q <= 4'h0;
        full_q <= 1'b0;
      end

      if (accept) begin
        asm_q[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_data;
        mask_q <= (move ? 4'h0 : mask_q) | (4'b0001 << ioctl_addr[1:0]);
        base_q <= wr_base;
        full_q <= (ioctl_addr[1:0] == 2'd3);
      end

      if (rise) begin
        words_q <= '0;
        ovf_q   <= 1'b0;
        mask_q  <= 4'h0;
        full_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE:  if (rise) state_q <= S_LOAD;
        S_LOAD:  if (!ioctl_download) state_q <= S_FLUSH;
        S_FLUSH: begin
          if ((mask_q == 4'h0) && !full_q && pend_free) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait    = pend_q;
  assign sdram_req     = pend_q;
  assign sdram_we      = pend_q;
  assign sdram_addr    = paddr_q;
  assign sdram_data    = pdata_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign words_written = words_q;
  assign overflow      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ioctl_sdram_writer.sv
// Directed self-checking bench for ioctl_sdram_writer (BASE_ADDR=0, PAD_BYTE=FF).
`default_nettype none

module tb_ioctl_sdram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        busy;
  logic        done;
  logic [22:0] words_written;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  ioctl_sdram_writer #(.BASE_ADDR(23'h0), .PAD_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .busy(busy), .done(done), .words_written(words_written), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack_once();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0;
    ioctl_download = 1'b0; sdram_ack = 1'b0;
    step(); step();
    chk("rst_req",   {31'd0, sdram_req}, 32'd0);
    chk("rst_we",    {31'd0, sdram_we}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_words", {9'd0, words_written}, 32'd0);
    chk("rst_addr",  {9'd0, sdram_addr}, 32'd0);
    chk("rst_data",  sdram_data, 32'd0);
    reset = 1'b0;
    step();

    // Single word, ack three cycles after req
    ioctl_download = 1'b1; step();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wr_byte(25'd0, 8'h11); wr_byte(25'd1, 8'h22); wr_byte(25'd2, 8'h33); wr_byte(25'd3, 8'h44);
    chk("t1_req_lat0", {31'd0, sdram_req}, 32'd0);
    step();
    chk("t1_req", {31'd0, sdram_req}, 32'd1);
    chk("t1_we", {31'd0, sdram_we}, 32'd1);
    chk("t1_wait", {31'd0, ioctl_wait}, 32'd1);
    chk("t1_addr", {9'd0, sdram_addr}, 32'd0);
    chk("t1_data", sdram_data, 32'h44332211);
    step(); step();
    chk("t1_hold_req", {31'd0, sdram_req}, 32'd1);
    chk("t1_hold_data", sdram_data, 32'h44332211);
    ack_once();
    chk("t1_req_drop", {31'd0, sdram_req}, 32'd0);
    chk("t1_words", {9'd0, words_written}, 32'd1);
    ioctl_download = 1'b0; step();
    chk("t1_flush_done", {31'd0, done}, 32'd0);
    chk("t1_flush_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1_done", {31'd0, done}, 32'd1);
    step();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Partial tail from byte address 0x100: word addresses 0x80 and 0x82
    ioctl_download = 1'b1; step();
    wr_byte(25'h100, 8'hAA); wr_byte(25'h101, 8'hBB); wr_byte(25'h102, 8'hCC);
    wr_byte(25'h103, 8'hDD); wr_byte(25'h104, 8'hEE); wr_byte(25'h105, 8'hFF);
    chk("t2_req_a", {31'd0, sdram_req}, 32'd1);
    chk("t2_addr_a", {9'd0, sdram_addr}, 32'h80);
    chk("t2_data_a", sdram_data, 32'hDDCCBBAA);
    ack_once();
    chk("t2_words_a", {9'd0, words_written}, 32'd1);
    ioctl_download = 1'b0; step();
    chk("t2_no_req_yet", {31'd0, sdram_req}, 32'd0);
    step();
    chk("t2_req_b", {31'd0, sdram_req}, 32'd1);
    chk("t2_addr_b", {9'd0, sdram_addr}, 32'h82);
    chk("t2_data_b", sdram_data, 32'hFFFFFFEE);
    chk("t2_no_done", {31'd0, done}, 32'd0);
    ack_once();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_words_b", {9'd0, words_written}, 32'd2);
    step();

    // Back-to-back: new word completes on the same edge as the ack
    ioctl_download = 1'b1; step();
    chk("t3_words_clr", {9'd0, words_written}, 32'd0);
    wr_byte(25'd0, 8'h01); wr_byte(25'd1, 8'h02); wr_byte(25'd2, 8'h03); wr_byte(25'd3, 8'h04);
    step();
    chk("t3_data_a", sdram_data, 32'h04030201);
    wr_byte(25'd4, 8'h05); wr_byte(25'd5, 8'h06); wr_byte(25'd6, 8'h07); wr_byte(25'd7, 8'h08);
    chk("t3_hold_a", sdram_data, 32'h04030201);
    ack_once();
    chk("t3_req_cont", {31'd0, sdram_req}, 32'd1);
    chk("t3_addr_b", {9'd0, sdram_addr}, 32'd2);
    chk("t3_data_b", sdram_data, 32'h08070605);
    chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
    chk("t3_words_1", {9'd0, words_written}, 32'd1);
    ack_once();
    chk("t3_req_off", {31'd0, sdram_req}, 32'd0);
    chk("t3_words_2", {9'd0, words_written}, 32'd2);
    ioctl_download = 1'b0; step(); step();
    chk("t3_done", {31'd0, done}, 32'd1);
    step();

    // Overflow: ack withheld, second word dropped
    ioctl_download = 1'b1; step();
    wr_byte(25'd0, 8'hA0); wr_byte(25'd1, 8'hA1); wr_byte(25'd2, 8'hA2); wr_byte(25'd3, 8'hA3);
    step();
    wr_byte(25'd4, 8'hB0); wr_byte(25'd5, 8'hB1); wr_byte(25'd6, 8'hB2); wr_byte(25'd7, 8'hB3);
    chk("t4_pre_ovf", {31'd0, overflow}, 32'd0);
    step();
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_kept_data", sdram_data, 32'hA3A2A1A0);
    chk("t4_kept_addr", {9'd0, sdram_addr}, 32'd0);
    ack_once();
    chk("t4_req_off", {31'd0, sdram_req}, 32'd0);
    chk("t4_words", {9'd0, words_written}, 32'd1);
    ioctl_download = 1'b0; step(); step();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
    step();

    // Address jump: partial flush at addr 0, new word at base 2
    ioctl_download = 1'b1; step();
    chk("t6_ovf_clr", {31'd0, overflow}, 32'd0);
    wr_byte(25'd0, 8'hAA); wr_byte(25'd1, 8'hBB); wr_byte(25'd8, 8'hCC);
    chk("t6_req", {31'd0, sdram_req}, 32'd1);
    chk("t6_addr_a", {9'd0, sdram_addr}, 32'd0);
    chk("t6_data_a", sdram_data, 32'hFFFFBBAA);
    ack_once();
    ioctl_download = 1'b0; step(); step();
    chk("t6_addr_b", {9'd0, sdram_addr}, 32'd4);
    chk("t6_data_b", sdram_data, 32'hFFFFFFCC);
    ack_once();
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_words", {9'd0, words_written}, 32'd2);
    step();

    // Reset while a request is outstanding
    ioctl_download = 1'b1; step();
    wr_byte(25'd0, 8'h10); wr_byte(25'd1, 8'h20); wr_byte(25'd2, 8'h30); wr_byte(25'd3, 8'h40);
    step(); ack_once();
    wr_byte(25'd4, 8'h50); wr_byte(25'd5, 8'h60); wr_byte(25'd6, 8'h70); wr_byte(25'd7, 8'h80);
    step();
    chk("t5_pre_req", {31'd0, sdram_req}, 32'd1);
    chk("t5_pre_words", {9'd0, words_written}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_req_async", {31'd0, sdram_req}, 32'd0);
    chk("t5_busy_async", {31'd0, busy}, 32'd0);
    chk("t5_words_async", {9'd0, words_written}, 32'd0);
    ioctl_download = 1'b0;
    step();
    reset = 1'b0;
    step();
    ioctl_download = 1'b1; step();
    chk("t5_restart_busy", {31'd0, busy}, 32'd1);
    wr_byte(25'd0, 8'h05); wr_byte(25'd1, 8'h06); wr_byte(25'd2, 8'h07); wr_byte(25'd3, 8'h08);
    step();
    chk("t5_restart_data", sdram_data, 32'h08070605);
    chk("t5_restart_addr", {9'd0, sdram_addr}, 32'd0);
    ack_once();
    chk("t5_restart_words", {9'd0, words_written}, 32'd1);
    ioctl_download = 1'b0; step(); step();
    chk("t5_restart_done", {31'd0, done}, 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
